// File: rtl/mio_bus_pkg.sv
// Shared types and constants for the memory/IO bus responder.
// Covers the FSM states, the decoded address regions and the address-map base nibbles.
package mio_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        RGN_RAM  = 3'd0,
        RGN_SEG  = 3'd1,
        RGN_GPIO = 3'd2,
        RGN_CNT  = 3'd3,
        RGN_NONE = 3'd4
    } region_t;

    localparam logic [3:0] BASE_RAM = 4'h0;
    localparam logic [3:0] BASE_SEG = 4'hE;
    localparam logic [3:0] BASE_IO  = 4'hF;

    localparam logic [3:0] IO_WAIT = 4'd1;

endpackage

// File: rtl/mio_addr_decode.sv
// Combinational address decoder: top address nibble plus addr[2] select the target region.
module mio_addr_decode
    import mio_bus_pkg::*;
(
    input  logic [3:0] base,
    input  logic       cnt_sel,
    output region_t    region
);

    always_comb begin
        region = RGN_NONE;
        case (base)
            BASE_RAM: region = RGN_RAM;
            BASE_SEG: region = RGN_SEG;
            BASE_IO:  region = cnt_sel ? RGN_CNT : RGN_GPIO;
            default:  region = RGN_NONE;
        endcase
    end

endmodule

// File: rtl/mio_bus_responder.sv
// Slave side of the CPU_MIO/MIO_ready handshake: latches one request, waits, then
// completes it with a registered MIO_ready pulse and at most one write strobe.
module mio_bus_responder
    import mio_bus_pkg::*;
#(
    parameter int unsigned RAM_WAIT = 2,
    parameter int unsigned RAM_AW   = 10
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              CPU_MIO,
    input  logic              mem_w,
    input  logic [31:0]       addr_bus,
    input  logic [31:0]       Data_out,
    output logic [31:0]       Data_in,
    output logic              MIO_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_we,
    input  logic [31:0]       ram_dout,
    output logic              gpio_we,
    output logic              seg_we,
    output logic              counter_we,
    output logic [31:0]       io_wdata,
    input  logic [15:0]       sw_in,
    input  logic [31:0]       counter_out
);

    localparam logic [3:0] RAM_WAIT_C = 4'(RAM_WAIT);

    state_t      state;
    region_t     dec_region;
    region_t     lat_region;
    logic        lat_we;
    logic [31:0] lat_data;
    logic [3:0]  wait_cnt;
    logic [31:0] rd_data;

    // Only the region nibble, addr[2] and the RAM word index take part in decoding.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_bus[31:RAM_AW+2], addr_bus[1:0]};

    mio_addr_decode u_decode (
        .base    (addr_bus[31:28]),
        .cnt_sel (addr_bus[2]),
        .region  (dec_region)
    );

    assign ram_din  = lat_data;
    assign io_wdata = lat_data;

    always_comb begin
        rd_data = '0;
        case (lat_region)
            RGN_RAM:           rd_data = ram_dout;
            RGN_SEG, RGN_GPIO: rd_data = {16'h0, sw_in};
            RGN_CNT:           rd_data = counter_out;
            default:           rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            lat_region <= RGN_NONE;
            lat_we     <= 1'b0;
            lat_data   <= '0;
            ram_addr   <= '0;
            Data_in    <= '0;
            MIO_ready  <= 1'b0;
            ram_we     <= 1'b0;
            gpio_we    <= 1'b0;
            seg_we     <= 1'b0;
            counter_we <= 1'b0;
        end else begin
            // Completion pulse and strobes are registered and last a single cycle.
            MIO_ready  <= 1'b0;
            ram_we     <= 1'b0;
            gpio_we    <= 1'b0;
            seg_we     <= 1'b0;
            counter_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (CPU_MIO) begin
                        lat_we     <= mem_w;
                        lat_data   <= Data_out;
                        ram_addr   <= addr_bus[RAM_AW+1:2];
                        lat_region <= dec_region;
                        wait_cnt   <= (dec_region == RGN_RAM) ? RAM_WAIT_C : IO_WAIT;
                        state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        if (!lat_we) begin
                            Data_in <= rd_data;
                        end
                        MIO_ready  <= 1'b1;
                        ram_we     <= lat_we && (lat_region == RGN_RAM);
                        gpio_we    <= lat_we && (lat_region == RGN_GPIO);
                        seg_we     <= lat_we && (lat_region == RGN_SEG);
                        counter_we <= lat_we && (lat_region == RGN_CNT);
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
